// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage.
//   Holds the PC, issues single-word reads to instruction memory (valid/ready
//   request, separate response), and buffers one fetched instruction.
//   It presents that instruction downstream with valid/ready. A redirect squashes
//   any in-flight or buffered work.
// Ports:
//   clock, reset_n               clock (rising edge), async active-low reset
//   imem_req/addr/ready          memory read request channel
//   imem_rvalid/rdata            memory read response
//   redirect_valid/pc            taken branch/jump target
//   instr_valid/ready            downstream handshake
//   instr, instr_pc              buffered word and its address
//   opcode, funct                instr[31:26], instr[5:0]
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
);

   typedef enum logic [2:0] {StBoot, StFetch, StWait, StHold, StDiscard} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] redirect_target;

   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      unique case (state_q)
         StBoot: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
               // An accepted request still returns data that must be dropped.
               state_d = imem_ready ? StDiscard : StFetch;
            end else if (imem_ready) begin
               inflight_pc_d = pc_q;
               state_d       = StWait;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               pc_d          = redirect_target;
               instr_valid_d = 1'b0;
               state_d       = imem_rvalid ? StFetch : StDiscard;
            end else if (imem_rvalid) begin
               instr_d       = imem_rdata;
               instr_pc_d    = inflight_pc_q;
               instr_valid_d = 1'b1;
               pc_d          = inflight_pc_q + 32'd4;
               state_d       = StHold;
            end
         end
         StHold: begin
            // A redirect wins even if downstream is consuming this cycle.
            if (redirect_valid) begin
               pc_d          = redirect_target;
               instr_valid_d = 1'b0;
               state_d       = StFetch;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = StFetch;
            end
         end
         StDiscard: begin
            if (redirect_valid) begin
               pc_d          = redirect_target;
               instr_valid_d = 1'b0;
            end else if (imem_rvalid) begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         inflight_pc_q <= 32'h0;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  opcode;
   logic [5:0]  funct;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .opcode        (opcode),
      .funct         (funct)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the fetch unit as "one outstanding request + one buffer slot".
   bit          m_boot;   // first cycle after reset: nothing happens yet
   bit          m_out;    // a memory request is outstanding
   bit          m_sq;     // that outstanding request has been squashed
   bit          m_bv;     // buffer holds an instruction
   logic [31:0] m_buf, m_bpc, m_pc, m_inf;

   // Memory responder state
   bit          mem_pend;
   int          mem_wait;
   logic [31:0] mem_data;

   function automatic bit exp_req();
      return !m_boot && !m_out && !m_bv;
   endfunction

   task automatic model_reset();
      m_boot = 1; m_out = 0; m_sq = 0; m_bv = 0;
      m_buf = '0; m_bpc = '0; m_pc = 32'h0; m_inf = '0;
      mem_pend = 0; mem_wait = 0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   task automatic compare_all();
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
      if (exp_req()) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_bv});
      if (m_bv) begin
         check("instr", instr, m_buf);
         check("instr_pc", instr_pc, m_bpc);
         check("opcode", {26'b0, opcode}, {26'b0, m_buf[31:26]});
         check("funct", {26'b0, funct}, {26'b0, m_buf[5:0]});
      end
   endtask

   task automatic model_update();
      bit fire, resp;
      if (!reset_n) return;
      if (imem_rvalid) mem_pend = 0;
      if (m_boot) begin
         m_boot = 0;
         return;
      end
      fire = exp_req() && imem_ready;
      resp = m_out && imem_rvalid;
      if (redirect_valid) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         m_bv = 0;
         if (resp) m_out = 0;
         if (fire) begin
            m_out = 1; m_sq = 1;
         end else if (m_out) begin
            m_sq = 1;
         end
      end else if (fire) begin
         m_out = 1; m_sq = 0; m_inf = m_pc;
      end else if (resp) begin
         m_out = 0;
         if (!m_sq) begin
            m_buf = imem_rdata; m_bpc = m_inf; m_bv = 1; m_pc = m_inf + 32'd4;
         end
      end else if (m_bv && instr_ready) begin
         m_bv = 0;
      end
      if (fire) begin
         mem_pend = 1;
         mem_wait = $urandom_range(0, 2);
         mem_data = $urandom;
      end
   endtask

   // One clock: inputs already driven; model steps on the edge, outputs checked mid-cycle.
   task automatic cycle();
      @(posedge clock);
      model_update();
      @(negedge clock);
      compare_all();
   endtask

   task automatic random_inputs();
      imem_ready = ($urandom % 4) != 0;
      if (mem_pend) begin
         if (mem_wait == 0) imem_rvalid = 1'b1;
         else begin
            imem_rvalid = 1'b0;
            mem_wait--;
         end
      end else begin
         imem_rvalid = ($urandom % 8) == 0;  // stray response pulses
      end
      imem_rdata     = (mem_pend && imem_rvalid) ? mem_data : $urandom;
      redirect_pc    = $urandom;
      // Avoid a redirect coinciding with the squashed response while discarding.
      redirect_valid = (($urandom % 8) == 0) && !(m_out && m_sq && imem_rvalid);
      instr_ready    = $urandom % 2;
   endtask

   initial begin
      reset_n = 1'b0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
      redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_opcode", {26'b0, opcode}, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      compare_all();

      // Release; one edge leaves boot, then request at address 0
      reset_n = 1'b1; imem_ready = 1;
      check("boot_req", {31'b0, imem_req}, 32'h0);
      cycle();
      check("first_req", {31'b0, imem_req}, 32'h1);
      check("first_addr", imem_addr, 32'h0);
      cycle();
      check("wait_req", {31'b0, imem_req}, 32'h0);
      imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h012A_4020;
      cycle();
      imem_rvalid = 0;
      check("d_valid", {31'b0, instr_valid}, 32'h1);
      check("d_opcode", {26'b0, opcode}, 32'h0);
      check("d_funct", {26'b0, funct}, 32'h20);
      check("d_instr_pc", instr_pc, 32'h0);

      // Stall in hold for 5 cycles
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_instr", instr, 32'h012A_4020);
         check("stall_req", {31'b0, imem_req}, 32'h0);
      end
      instr_ready = 1;
      cycle();
      instr_ready = 0;
      check("next_req", {31'b0, imem_req}, 32'h1);
      check("next_addr", imem_addr, 32'h4);

      // Redirect while waiting; late data is dropped
      imem_ready = 1;
      cycle();
      imem_ready = 0; redirect_valid = 1; redirect_pc = 32'h0000_0103;
      cycle();
      redirect_valid = 0;
      cycle();
      check("disc_req", {31'b0, imem_req}, 32'h0);
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
      cycle();
      imem_rvalid = 0;
      check("disc_valid", {31'b0, instr_valid}, 32'h0);
      check("disc_addr", imem_addr, 32'h100);
      check("disc_req2", {31'b0, imem_req}, 32'h1);

      // Redirect in hold with a simultaneous instr_ready
      imem_ready = 1;
      cycle();
      imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h8C43_0004;
      cycle();
      imem_rvalid = 0;
      check("h_instr_pc", instr_pc, 32'h100);
      check("h_opcode", {26'b0, opcode}, 32'h23);
      redirect_valid = 1; redirect_pc = 32'h0000_0200; instr_ready = 1;
      cycle();
      redirect_valid = 0; instr_ready = 0;
      check("h_valid", {31'b0, instr_valid}, 32'h0);
      check("h_addr", imem_addr, 32'h200);

      // Wrap-around fetch at 0xFFFFFFFC
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
      cycle();
      redirect_valid = 0;
      check("w_addr", imem_addr, 32'hFFFF_FFFC);
      imem_ready = 1;
      cycle();
      imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0000;
      cycle();
      imem_rvalid = 0; instr_ready = 1;
      check("w_instr_pc", instr_pc, 32'hFFFF_FFFC);
      cycle();
      instr_ready = 0;
      check("w_next_addr", imem_addr, 32'h0);

      // Reset mid-wait, then a stray response after release
      imem_ready = 1;
      cycle();
      imem_ready = 0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("mr_req", {31'b0, imem_req}, 32'h0);
      check("mr_valid", {31'b0, instr_valid}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
      cycle();
      cycle();
      imem_rvalid = 0;
      check("mr_req2", {31'b0, imem_req}, 32'h1);
      check("mr_addr", imem_addr, 32'h0);
      check("mr_valid2", {31'b0, instr_valid}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         random_inputs();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
